// File: rtl/rect_count_stream_if.sv
// Pixel-stream input and per-frame result port of rect_count_stream.
interface rect_count_stream_if #(
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 18
);
    logic             s_valid;
    logic             s_ready;
    logic             s_sof;
    logic [LANES-1:0] s_data;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;

    // Producer of pixels / consumer of results.
    modport master (
        output s_valid, s_sof, s_data, res_ready,
        input  s_ready, res_valid, res_count
    );

    // The rectangle counter itself.
    modport slave (
        input  s_valid, s_sof, s_data, res_ready,
        output s_ready, res_valid, res_count
    );
endinterface

// File: rtl/rect_count_stream.sv
// Streaming rectangle counter: counts top-left corners (p=1, left=0, above=0)
// of solid 1-pixel rectangles over a raster image, LANES pixels per beat.
// Optional: define RECT_COUNT_ABORT_CNT_EN to add a saturating abort_cnt output.
module rect_count_stream #(
    parameter int unsigned IMG_W = 1024,
    parameter int unsigned IMG_H = 512,
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = $clog2(((IMG_W + 1) / 2) * ((IMG_H + 1) / 2) + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rect_count_stream_if.slave    bus
`ifdef RECT_COUNT_ABORT_CNT_EN
    ,
    output logic [15:0]           abort_cnt
`endif
);
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned INC_W = $clog2(LANES + 1);

    // Frame width must be a whole number of beats.
    if ((IMG_W % LANES) != 0) begin : g_bad_lanes
        $error("rect_count_stream: LANES must divide IMG_W");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             prev_q, prev_d;
    logic             s_ready_q, s_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [IMG_W-1:0] line_q;

    logic             accept_c;
    logic             start_c;
    logic             take_c;
    logic             abort_c;
    logic [COL_W-1:0] eff_col_c;
    logic [ROW_W-1:0] eff_row_c;
    logic [LANES-1:0] left_c;
    logic [LANES-1:0] above_c;
    logic [LANES-1:0] corner_c;
    logic [INC_W-1:0] inc_c;
    logic [CNT_W-1:0] beat_acc_c;
    logic             last_col_c;
    logic             last_row_c;

    // Beat qualification and position of the beat being taken.
    always_comb begin
        accept_c  = bus.s_valid && s_ready_q;
        start_c   = accept_c && bus.s_sof;
        take_c    = (state_q == ACTIVE && accept_c) || (state_q == IDLE && start_c);
        abort_c   = (state_q == ACTIVE) && start_c;
        eff_col_c = start_c ? '0 : col_q;
        eff_row_c = start_c ? '0 : row_q;
    end

    // Corner detection and popcount of the beat's corner flags.
    always_comb begin
        left_c   = LANES'({bus.s_data, ((eff_col_c == '0) ? 1'b0 : prev_q)});
        above_c  = (eff_row_c == '0) ? '0 : line_q[eff_col_c +: LANES];
        corner_c = bus.s_data & ~left_c & ~above_c;
        inc_c    = '0;
        for (int i = 0; i < LANES; i++) begin
            inc_c = inc_c + INC_W'(corner_c[i]);
        end
        beat_acc_c = start_c ? CNT_W'(inc_c) : acc_q + CNT_W'(inc_c);
        last_col_c = (eff_col_c == COL_W'(IMG_W - LANES));
        last_row_c = (eff_row_c == ROW_W'(IMG_H - 1));
    end

    // Next-state: frame sequencing, position counters and result capture.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_d       = acc_q;
        prev_d      = prev_q;
        res_valid_d = res_valid_q;
        res_count_d = res_count_q;
        case (state_q)
            IDLE, ACTIVE: begin
                if (take_c) begin
                    acc_d   = beat_acc_c;
                    prev_d  = bus.s_data[LANES-1];
                    state_d = ACTIVE;
                    if (last_col_c) begin
                        col_d = '0;
                        if (last_row_c) begin
                            row_d       = '0;
                            state_d     = REPORT;
                            res_valid_d = 1'b1;
                            res_count_d = beat_acc_c;
                        end else begin
                            row_d = eff_row_c + ROW_W'(1);
                        end
                    end else begin
                        col_d = eff_col_c + COL_W'(LANES);
                        row_d = eff_row_c;
                    end
                end
            end
            REPORT: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        s_ready_d = (state_d != REPORT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            prev_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            prev_q      <= prev_d;
            s_ready_q   <= s_ready_d;
            res_valid_q <= res_valid_d;
            res_count_q <= res_count_d;
        end
    end

    // Previous-row line buffer; rows never read before being written, so no reset.
    always_ff @(posedge clk) begin
        if (take_c) begin
            line_q[eff_col_c +: LANES] <= bus.s_data;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_count = res_count_q;

`ifdef RECT_COUNT_ABORT_CNT_EN
    logic [15:0] abort_q, abort_d;

    // Saturating count of frames restarted by a mid-frame sof.
    always_comb begin
        abort_d = abort_q;
        if (abort_c && (abort_q != 16'hFFFF)) begin
            abort_d = abort_q + 16'd1;
        end
    end

    // Abort counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= '0;
        end else begin
            abort_q <= abort_d;
        end
    end

    assign abort_cnt = abort_q;
`else
    logic unused_abort;
    assign unused_abort = abort_c;
`endif
endmodule

// File: tb/tb_rect_count_stream.sv
// Directed bench for rect_count_stream: an 8x4 image through a 1-lane and a 4-lane instance.
module tb_rect_count_stream;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rect_count_stream_if #(.LANES(1), .CNT_W(CW)) ia ();
    rect_count_stream_if #(.LANES(4), .CNT_W(CW)) ib ();

`ifdef RECT_COUNT_ABORT_CNT_EN
    logic [15:0] abort_a;
    logic [15:0] abort_b;
`endif

    rect_count_stream #(.IMG_W(W), .IMG_H(H), .LANES(1), .CNT_W(CW)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ia)
`ifdef RECT_COUNT_ABORT_CNT_EN
        ,
        .abort_cnt (abort_a)
`endif
    );

    rect_count_stream #(.IMG_W(W), .IMG_H(H), .LANES(4), .CNT_W(CW)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ib)
`ifdef RECT_COUNT_ABORT_CNT_EN
        ,
        .abort_cnt (abort_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int u);
        return (u == 0) ? ia.s_ready : ib.s_ready;
    endfunction

    function automatic logic get_valid(input int u);
        return (u == 0) ? ia.res_valid : ib.res_valid;
    endfunction

    function automatic logic [CW-1:0] get_count(input int u);
        return (u == 0) ? ia.res_count : ib.res_count;
    endfunction

    // One beat: present at negedge, wait (bounded) for ready, accept on posedge.
    task automatic push(input int u, input logic sof, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        if (u == 0) begin
            ia.s_valid = 1'b1; ia.s_sof = sof; ia.s_data = d[0];
        end else begin
            ib.s_valid = 1'b1; ib.s_sof = sof; ib.s_data = d;
        end
        while (get_ready(u) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("push_ready", 32'(get_ready(u)), 32'd1);
        @(posedge clk);
        #1;
        ia.s_valid = 1'b0; ia.s_sof = 1'b0;
        ib.s_valid = 1'b0; ib.s_sof = 1'b0;
    endtask

    // Beats [from, to) of a raster image; beat 0 carries sof.
    task automatic send(input int u, input logic [31:0] img, input int from, input int to);
        int l;
        logic [3:0] d;
        l = (u == 0) ? 1 : 4;
        for (int k = from; k < to; k++) begin
            d = 4'(img >> (k * l));
            if (l == 1) d = {3'b000, d[0]};
            push(u, (k == 0), d);
        end
    endtask

    // Called #1 after the final beat: check result, then handshake it.
    task automatic take(input int u, input logic [CW-1:0] exp, input string tag);
        check_eq({tag, "_valid"}, 32'(get_valid(u)), 32'd1);
        check_eq({tag, "_count"}, 32'(get_count(u)), 32'(exp));
        @(negedge clk);
        if (u == 0) ia.res_ready = 1'b1; else ib.res_ready = 1'b1;
        @(posedge clk);
        #1;
        ia.res_ready = 1'b0;
        ib.res_ready = 1'b0;
        check_eq({tag, "_done"}, 32'(get_valid(u)), 32'd0);
        check_eq({tag, "_rdy"}, 32'(get_ready(u)), 32'd1);
    endtask

    task automatic frame(input int u, input logic [31:0] img, input logic [CW-1:0] exp, input string tag);
        int nb;
        nb = (u == 0) ? 32 : 8;
        send(u, img, 0, nb - 1);
        check_eq({tag, "_early"}, 32'(get_valid(u)), 32'd0);
        send(u, img, nb - 1, nb);
        take(u, exp, tag);
    endtask

    initial begin
        ia.s_valid = 1'b0; ia.s_sof = 1'b0; ia.s_data = '0; ia.res_ready = 1'b0;
        ib.s_valid = 1'b0; ib.s_sof = 1'b0; ib.s_data = '0; ib.res_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(ia.s_ready), 32'd0);
        check_eq("rst_valid", 32'(ia.res_valid), 32'd0);
        check_eq("rst_count", 32'(ia.res_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_ready_a", 32'(ia.s_ready), 32'd1);
        check_eq("rel_ready_b", 32'(ib.s_ready), 32'd1);

        frame(0, 32'h0000_0000, 4'd0, "zero");
        frame(0, 32'h001C_1C00, 4'd1, "blk3x2");
        frame(0, 32'h0055_0055, 4'd8, "iso_even");
        frame(1, 32'h0000_1818, 4'd1, "blk_cross");
        frame(1, 32'hAA00_AA00, 4'd8, "iso_odd");

        // Backpressure on the result port.
        send(0, 32'h001C_1C00, 0, 32);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ready", 32'(ia.s_ready), 32'd0);
            check_eq("bp_valid", 32'(ia.res_valid), 32'd1);
            check_eq("bp_count", 32'(ia.res_count), 32'd1);
            @(posedge clk);
            #1;
        end
        take(0, 4'd1, "bp");

        // Abandoned frame of all-ones, restarted by sof.
        send(0, 32'hFFFF_FFFF, 0, 10);
        check_eq("abort_novalid", 32'(ia.res_valid), 32'd0);
        frame(0, 32'h001C_1C00, 4'd1, "abort");
`ifdef RECT_COUNT_ABORT_CNT_EN
        check_eq("abort_cnt_a", 32'(abort_a), 32'd1);
        check_eq("abort_cnt_b", 32'(abort_b), 32'd0);
`endif

        // Reset with B holding a result and A mid-frame.
        send(1, 32'h0000_1818, 0, 8);
        check_eq("pend_b", 32'(ib.res_valid), 32'd1);
        send(0, 32'hFFFF_FFFF, 0, 20);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid_a", 32'(ia.res_valid), 32'd0);
        check_eq("mid_rst_count_a", 32'(ia.res_count), 32'd0);
        check_eq("mid_rst_valid_b", 32'(ib.res_valid), 32'd0);
        check_eq("mid_rst_count_b", 32'(ib.res_count), 32'd0);
        check_eq("mid_rst_ready", 32'(ia.s_ready), 32'd0);
`ifdef RECT_COUNT_ABORT_CNT_EN
        check_eq("mid_rst_abort", 32'(abort_a), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) push(0, 1'b0, 4'b0001);
        check_eq("discard_valid", 32'(ia.res_valid), 32'd0);
        frame(0, 32'h0055_0055, 4'd8, "post_rst");
        frame(1, 32'h001C_1C00, 4'd1, "post_rst_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
